iob2axil: RTL and testbench
===========================

Name: iob2axil

Overview:
- Bridges the native (IOb) interface to AXI4-Lite, in the opposite direction from the AXI4-Lite-slave-to-native bridge.
- Acts as a native slave towards a CPU or peripheral master, and as an AXI4-Lite master towards an interconnect or AXI-Lite peripheral.
- Handles one outstanding transaction at a time.
- Decodes writes from a nonzero wstrb and reads from a zero wstrb, then runs the full AXI handshake sequence before returning ready.

Parameters:
- AXIL_ADDR_W, 32, address width in bits.
- AXIL_DATA_W, 32, data width in bits; must be 32 or 64; strobe width is AXIL_DATA_W/8.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  native request; held by the master until ready is seen.
- addr  in  AXIL_ADDR_W  native byte address.
- wdata  in  AXIL_DATA_W  native write data.
- wstrb  in  AXIL_DATA_W/8  byte enables; all-zero means read.
- rdata  out  AXIL_DATA_W  read data; valid only while ready=1.
- ready  out  1  single-cycle completion pulse.
- resp_err  out  1  qualified by ready; 1 if the AXI response was not OKAY.
- axil_awaddr  out  AXIL_ADDR_W  write address.
- axil_awprot  out  3  constant 3'b010.
- axil_awvalid  out  1  write address valid.
- axil_awready  in  1  write address ready.
- axil_wdata  out  AXIL_DATA_W  write data.
- axil_wstrb  out  AXIL_DATA_W/8  write strobes.
- axil_wvalid  out  1  write data valid.
- axil_wready  in  1  write data ready.
- axil_bresp  in  2  write response code.
- axil_bvalid  in  1  write response valid.
- axil_bready  out  1  write response ready.
- axil_araddr  out  AXIL_ADDR_W  read address.
- axil_arprot  out  3  constant 3'b010.
- axil_arvalid  out  1  read address valid.
- axil_arready  in  1  read address ready.
- axil_rdata  in  AXIL_DATA_W  read data.
- axil_rresp  in  2  read response code.
- axil_rvalid  in  1  read data valid.
- axil_rready  out  1  read data ready.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE; every output is 0, including ready, resp_err, rdata, all AXI valid/ready signals, and all address/data/strobe registers.
- Any in-flight AXI transaction is abandoned; the interconnect is reset with the same rst_n.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE, valid=1: register addr, wdata and wstrb into the AXI output registers.
  - If wstrb != 0: go to WR_ADDR_DATA; axil_awvalid=1 and axil_wvalid=1 from the next cycle.
  - If wstrb == 0: go to RD_ADDR; axil_arvalid=1.
- WR_ADDR_DATA: the AW and W channels complete independently.
  - On axil_awvalid&axil_awready, clear axil_awvalid.
  - On axil_wvalid&axil_wready, clear axil_wvalid.
  - Either order is legal, as is the same cycle.
  - When both are done (including both completing in the same cycle), go to WR_RESP.
  - A valid is never withdrawn before its handshake.
  - axil_awaddr, axil_wdata and axil_wstrb stay stable while the corresponding valid is high.
- WR_RESP: axil_bready=1.
  - On axil_bvalid: capture resp_err=(axil_bresp!=2'b00), set rdata=0, go to DONE.
- RD_ADDR: on axil_arready, clear axil_arvalid and go to RD_DATA.
- RD_DATA: axil_rready=1.
  - On axil_rvalid: register rdata=axil_rdata and resp_err=(axil_rresp!=2'b00), go to DONE.
- DONE: ready=1 for exactly one cycle, then return to IDLE.
  - rdata and resp_err hold their values until the next completion.
  - valid may still be high in the DONE cycle; it is ignored there.
  - A new request is sampled in IDLE on the next cycle.
- Minimum latency with zero-wait AXI slaves is 3 cycles, for both reads and writes:
  - cycle 0: valid sampled in IDLE;
  - cycle 1: address (and data) handshake;
  - cycle 2: response handshake;
  - cycle 3: ready=1.
- Back-to-back throughput is at best one transaction per 4 cycles.
- AXI slave stalls (ready or valid held low) extend the corresponding state indefinitely; there is no timeout.
- addr, wdata and wstrb changing while the FSM is not in IDLE have no effect, since they are registered at acceptance.
- A SLVERR or DECERR response still completes normally, with resp_err=1 during the ready cycle.

Test Plan:
- Reset mid-write:
  - Stimulus: drop rst_n while in WR_ADDR_DATA with axil_awvalid=1.
  - Response: all outputs read 0 immediately, without waiting for clk; after release, the FSM is in IDLE and a new read completes correctly.
- Single write, zero-wait slave:
  - Stimulus: valid=1, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, with awready=wready=bvalid=1.
  - Response: awaddr=0x10 and wdata=0xDEADBEEF on cycle 1; ready=1, resp_err=0 on cycle 3; exactly one AW, one W and one B handshake.
- Skewed write channels:
  - Stimulus: wready asserted 4 cycles before awready, with wstrb=0x3.
  - Response: wvalid drops after its handshake while awvalid stays high; ready pulses 2 cycles after the AW handshake; axil_wstrb=0x3.
- Read with wait states and error:
  - Stimulus: addr=0x24, wstrb=0; arready delayed 2 cycles, rvalid delayed 3 cycles, rdata=0x12345678, rresp=2'b10.
  - Response: ready pulses one cycle after the R handshake with rdata=0x12345678 and resp_err=1.
- Back-to-back requests:
  - Stimulus: valid held high across a write to 0x0 followed by a read from 0x4.
  - Response: the read's arvalid rises exactly 2 cycles after the write's ready pulse; no duplicate write is issued.

Source files
------------

// File: rtl/iob2axil.sv
// iob2axil: native (IOb) slave to AXI4-Lite master bridge.
//
// Accepts one native request at a time, replays it as a full AXI4-Lite
// transaction and then returns a single-cycle ready pulse.
// A nonzero wstrb selects a write and an all-zero wstrb selects a read.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid/addr/wdata/wstrb      native request, held by the master until ready
//   rdata/ready/resp_err        native completion; rdata and resp_err are
//                               qualified by ready
//   axil_aw*/axil_w*/axil_b*    AXI4-Lite write channels (master side)
//   axil_ar*/axil_r*            AXI4-Lite read channels (master side)
//
// AXIL_DATA_W must be 32 or 64. The strobe width is AXIL_DATA_W/8.
module iob2axil #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // native slave
  input  logic                     valid,
  input  logic [AXIL_ADDR_W-1:0]   addr,
  input  logic [AXIL_DATA_W-1:0]   wdata,
  input  logic [AXIL_DATA_W/8-1:0] wstrb,
  output logic [AXIL_DATA_W-1:0]   rdata,
  output logic                     ready,
  output logic                     resp_err,
  // AXI4-Lite write address
  output logic [AXIL_ADDR_W-1:0]   axil_awaddr,
  output logic [2:0]               axil_awprot,
  output logic                     axil_awvalid,
  input  logic                     axil_awready,
  // AXI4-Lite write data
  output logic [AXIL_DATA_W-1:0]   axil_wdata,
  output logic [AXIL_DATA_W/8-1:0] axil_wstrb,
  output logic                     axil_wvalid,
  input  logic                     axil_wready,
  // AXI4-Lite write response
  input  logic [1:0]               axil_bresp,
  input  logic                     axil_bvalid,
  output logic                     axil_bready,
  // AXI4-Lite read address
  output logic [AXIL_ADDR_W-1:0]   axil_araddr,
  output logic [2:0]               axil_arprot,
  output logic                     axil_arvalid,
  input  logic                     axil_arready,
  // AXI4-Lite read data
  input  logic [AXIL_DATA_W-1:0]   axil_rdata,
  input  logic [1:0]               axil_rresp,
  input  logic                     axil_rvalid,
  output logic                     axil_rready
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [AXIL_ADDR_W-1:0] addr_q;
  logic [AXIL_DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0]      wstrb_q;
  logic [AXIL_DATA_W-1:0] rdata_q;
  logic                   resp_err_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   arvalid_q;

  // A write channel counts as finished once its valid has dropped or its
  // handshake is happening this cycle, so AW and W may complete in either
  // order or together.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || axil_awready;
  assign w_done  = !wvalid_q  || axil_wready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (valid) state_nxt = (|wstrb) ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_done && w_done) state_nxt = WR_RESP;
      WR_RESP:      if (axil_bvalid) state_nxt = DONE;
      RD_ADDR:      if (axil_arready) state_nxt = RD_DATA;
      RD_DATA:      if (axil_rvalid) state_nxt = DONE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (valid) begin
            // Capture the request at acceptance; later changes on the
            // native inputs cannot disturb the AXI transaction.
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            if (|wstrb) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              arvalid_q <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (axil_awready) awvalid_q <= 1'b0;
          if (axil_wready)  wvalid_q  <= 1'b0;
        end
        WR_RESP: begin
          if (axil_bvalid) begin
            resp_err_q <= (axil_bresp != 2'b00);
            rdata_q    <= '0;
          end
        end
        RD_ADDR: begin
          if (axil_arready) arvalid_q <= 1'b0;
        end
        RD_DATA: begin
          if (axil_rvalid) begin
            resp_err_q <= (axil_rresp != 2'b00);
            rdata_q    <= axil_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // ready and the response-channel ready signals depend only on the state.
  // Reset therefore clears them immediately.
  assign ready       = (state == DONE);
  assign axil_bready = (state == WR_RESP);
  assign axil_rready = (state == RD_DATA);

  assign rdata    = rdata_q;
  assign resp_err = resp_err_q;

  // The address register is shared because only one transaction is in flight.
  assign axil_awaddr  = addr_q;
  assign axil_araddr  = addr_q;
  assign axil_awprot  = 3'b010;
  assign axil_arprot  = 3'b010;
  assign axil_awvalid = awvalid_q;
  assign axil_wdata   = wdata_q;
  assign axil_wstrb   = wstrb_q;
  assign axil_wvalid  = wvalid_q;
  assign axil_arvalid = arvalid_q;

endmodule

// File: tb/tb_iob2axil.sv
module tb_iob2axil;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        ready, resp_err;
  logic [31:0] axil_awaddr, axil_wdata, axil_araddr, axil_rdata;
  logic [2:0]  axil_awprot, axil_arprot;
  logic        axil_awvalid, axil_awready, axil_wvalid, axil_wready;
  logic [3:0]  axil_wstrb;
  logic [1:0]  axil_bresp, axil_rresp;
  logic        axil_bvalid, axil_bready, axil_arvalid, axil_arready;
  logic        axil_rvalid, axil_rready;

  int total = 0;
  int bad   = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

  iob2axil dut (
    .clk(clk), .rst_n(rst_n),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .resp_err(resp_err),
    .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
    .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
    .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
    .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
    .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
    .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
    .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
    .axil_rvalid(axil_rvalid), .axil_rready(axil_rready)
  );

  always #5 clk = ~clk;

  // handshake counters
  always @(posedge clk) begin
    if (axil_awvalid && axil_awready) aw_hs++;
    if (axil_wvalid  && axil_wready)  w_hs++;
    if (axil_bvalid  && axil_bready)  b_hs++;
    if (axil_arvalid && axil_arready) ar_hs++;
    if (axil_rvalid  && axil_rready)  r_hs++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axil_awready = 0; axil_wready = 0; axil_bvalid = 0; axil_bresp = 2'b00;
    axil_arready = 0; axil_rvalid = 0; axil_rresp = 2'b00; axil_rdata = '0;
  endtask

  initial begin
    rst_n = 0; valid = 0; addr = '0; wdata = '0; wstrb = '0;
    slave_idle();
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_awvalid", axil_awvalid, 0);
    chk("rst_arvalid", axil_arvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("awprot", axil_awprot, 3'b010);
    chk("arprot", axil_arprot, 3'b010);
    #9 rst_n = 1;
    tick();

    // ---- single write, zero-wait slave ----
    valid = 1; addr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    axil_awready = 1; axil_wready = 1; axil_bvalid = 1; axil_bresp = 2'b00;
    tick(); // cycle 1
    chk("wr1_awvalid", axil_awvalid, 1);
    chk("wr1_wvalid", axil_wvalid, 1);
    chk("wr1_awaddr", axil_awaddr, 32'h10);
    chk("wr1_wdata", axil_wdata, 32'hDEADBEEF);
    chk("wr1_wstrb", axil_wstrb, 4'hF);
    chk("wr1_ready_c1", ready, 0);
    tick(); // cycle 2
    chk("wr1_bready", axil_bready, 1);
    chk("wr1_awvalid_c2", axil_awvalid, 0);
    chk("wr1_ready_c2", ready, 0);
    tick(); // cycle 3
    chk("wr1_ready_c3", ready, 1);
    chk("wr1_resp_err", resp_err, 0);
    chk("wr1_rdata", rdata, 0);
    valid = 0; slave_idle();
    tick();
    chk("wr1_ready_pulse", ready, 0);
    chk("wr1_aw_hs", aw_hs, 1);
    chk("wr1_w_hs", w_hs, 1);
    chk("wr1_b_hs", b_hs, 1);

    // ---- skewed write channels, W first, DECERR response ----
    valid = 1; addr = 32'h20; wdata = 32'hA5A5A5A5; wstrb = 4'h3;
    axil_wready = 1;
    tick(); // c1: W handshake at end of this cycle
    chk("sk_awvalid_c1", axil_awvalid, 1);
    chk("sk_wvalid_c1", axil_wvalid, 1);
    tick(); // c2
    axil_wready = 0;
    chk("sk_wvalid_drop", axil_wvalid, 0);
    chk("sk_awvalid_hold", axil_awvalid, 1);
    chk("sk_wstrb", axil_wstrb, 4'h3);
    addr = 32'hFFF0; wdata = 32'h0; wstrb = 4'hC;
    tick(); // c3
    chk("sk_awaddr_stable", axil_awaddr, 32'h20);
    tick(); // c4
    chk("sk_awvalid_c4", axil_awvalid, 1);
    chk("sk_bready_c4", axil_bready, 0);
    tick(); // c5
    axil_awready = 1; axil_bvalid = 1; axil_bresp = 2'b11;
    tick(); // c6
    axil_awready = 0;
    chk("sk_awvalid_c6", axil_awvalid, 0);
    chk("sk_ready_c6", ready, 0);
    tick(); // c7
    chk("sk_ready_c7", ready, 1);
    chk("sk_resp_err", resp_err, 1);
    chk("sk_wstrb_kept", axil_wstrb, 4'h3);
    valid = 0; slave_idle();
    tick();
    chk("sk_aw_hs", aw_hs, 2);
    chk("sk_w_hs", w_hs, 2);

    // ---- read with wait states and SLVERR ----
    valid = 1; addr = 32'h24; wstrb = 4'h0;
    tick(); // c1
    chk("rd_arvalid_c1", axil_arvalid, 1);
    chk("rd_araddr", axil_araddr, 32'h24);
    chk("rd_awvalid", axil_awvalid, 0);
    tick(); // c2
    chk("rd_arvalid_c2", axil_arvalid, 1);
    tick(); // c3
    axil_arready = 1;
    tick(); // c4
    axil_arready = 0;
    chk("rd_arvalid_c4", axil_arvalid, 0);
    chk("rd_rready", axil_rready, 1);
    tick(); // c5
    chk("rd_ready_c5", ready, 0);
    tick(); // c6
    axil_rvalid = 1; axil_rdata = 32'h12345678; axil_rresp = 2'b10;
    tick(); // c7
    chk("rd_ready", ready, 1);
    chk("rd_rdata", rdata, 32'h12345678);
    chk("rd_resp_err", resp_err, 1);
    valid = 0; slave_idle();
    tick();
    chk("rd_ready_pulse", ready, 0);
    chk("rd_rdata_hold", rdata, 32'h12345678);
    chk("rd_ar_hs", ar_hs, 1);

    // ---- back-to-back write then read, valid held high ----
    valid = 1; addr = 32'h0; wdata = 32'h11111111; wstrb = 4'hF;
    axil_awready = 1; axil_wready = 1; axil_bvalid = 1;
    axil_arready = 1; axil_rvalid = 1; axil_rdata = 32'hCAFEF00D; axil_rresp = 2'b01;
    tick(); tick(); tick(); // c3
    chk("bb_wr_ready", ready, 1);
    addr = 32'h4; wstrb = 4'h0;
    tick(); // c4
    chk("bb_ready_c4", ready, 0);
    chk("bb_arvalid_c4", axil_arvalid, 0);
    chk("bb_awvalid_c4", axil_awvalid, 0);
    tick(); // c5
    chk("bb_arvalid_c5", axil_arvalid, 1);
    chk("bb_araddr", axil_araddr, 32'h4);
    chk("bb_no_dup_aw", axil_awvalid, 0);
    tick(); tick(); // c7
    chk("bb_rd_ready", ready, 1);
    chk("bb_rdata", rdata, 32'hCAFEF00D);
    chk("bb_resp_err", resp_err, 1);
    chk("bb_aw_hs", aw_hs, 3);
    valid = 0; slave_idle();
    tick();

    // ---- reset mid-write ----
    valid = 1; addr = 32'h30; wdata = 32'h55AA55AA; wstrb = 4'hF;
    tick(); tick();
    chk("mr_awvalid_pre", axil_awvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("mr_awvalid", axil_awvalid, 0);
    chk("mr_wvalid", axil_wvalid, 0);
    chk("mr_awaddr", axil_awaddr, 0);
    chk("mr_wdata", axil_wdata, 0);
    chk("mr_wstrb", axil_wstrb, 0);
    chk("mr_rdata", rdata, 0);
    chk("mr_resp_err", resp_err, 0);
    chk("mr_ready", ready, 0);
    valid = 0;
    tick();
    #2 rst_n = 1;
    tick();
    chk("mr_idle_awvalid", axil_awvalid, 0);
    valid = 1; addr = 32'h8; wstrb = 4'h0;
    axil_arready = 1; axil_rvalid = 1; axil_rdata = 32'h0BADF00D; axil_rresp = 2'b00;
    tick(); // c1
    chk("mr_rd_arvalid", axil_arvalid, 1);
    tick(); tick(); // c3
    chk("mr_rd_ready", ready, 1);
    chk("mr_rd_rdata", rdata, 32'h0BADF00D);
    chk("mr_rd_resp_err", resp_err, 0);
    valid = 0; slave_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
